rx_block_assembler: RTL

RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

---
 rtl/rx_pkg.sv | 10 +
 rtl/rx_byte_counter.sv | 32 +++
 rtl/rx_block_assembler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared widths, defaults and FSM state type for the RX block assembler.
package rx_pkg;
    localparam int BYTE_W            = 8;
    localparam int DEFAULT_NUM_BYTES = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/rx_byte_counter.sv
// Fill-slot counter: synchronous clear (priority) and increment, one cycle per update.
// Flags the final slot (last) and a fill buffer stalled full (full); no backpressure of its own.
module rx_byte_counter
    import rx_pkg::*;
#(
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
    parameter int CNT_W     = $clog2(NUM_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last,
    output logic             o_full
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(NUM_BYTES - 1));
    assign o_full  = (r_count == CNT_W'(NUM_BYTES));
endmodule

// File: rtl/rx_block_assembler.sv
// Packs strobed bytes MSB-first into NUM_BYTES blocks; block_valid rises on the edge sampling the last byte.
// Held block waits for block_ready; strobes that cannot be stored are dropped with a one-cycle overrun pulse (RX_DOUBLE_BUFFER_EN adds a fill buffer).
module rx_block_assembler
    import rx_pkg::*;
#(
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              byte_strobe,
    input  logic [BYTE_W-1:0]                 byte_in,
    input  logic                              clear,
    input  logic                              block_ready,
    output logic                              block_valid,
    output logic [BYTE_W*NUM_BYTES-1:0]       block_out,
    output logic [$clog2(NUM_BYTES+1)-1:0]    fill_count,
    output logic                              overrun
);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int BLK_W = BYTE_W * NUM_BYTES;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic [BLK_W-1:0]   r_fill;
    logic [BLK_W-1:0]   w_fill_wr_dat;
    logic               w_fill_wr;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_last;
    logic               w_full;
    logic               w_transfer;
    logic [CNT_W-1:0]   w_count;
`ifdef RX_DOUBLE_BUFFER_EN
    logic [BLK_W-1:0]   r_out;
    logic               w_out_ld_new;
    logic               w_out_ld_fill;
`endif

    rx_byte_counter #(
        .NUM_BYTES (NUM_BYTES),
        .CNT_W     (CNT_W)
    ) u_byte_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_clear (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_count),
        .o_last  (w_last),
        .o_full  (w_full)
    );

    assign w_transfer = (r_state == ST_HOLD) && block_ready;

    // Fill buffer with the incoming byte merged at the current slot; slot 0 is the MSB byte.
    always_comb begin
        w_fill_wr_dat = r_fill;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (w_count == CNT_W'(k)) begin
                w_fill_wr_dat[BLK_W-BYTE_W*(k+1) +: BYTE_W] = byte_in;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_nxt = 1'b0;
        w_fill_wr     = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
`ifdef RX_DOUBLE_BUFFER_EN
        w_out_ld_new  = 1'b0;
        w_out_ld_fill = 1'b0;
`endif
        if (clear) begin
            w_state_nxt = ST_FILL;
            w_cnt_clr   = 1'b1;
        end else begin
`ifdef RX_DOUBLE_BUFFER_EN
            if (w_transfer) begin
                w_state_nxt = ST_FILL;
            end
            if (w_full) begin
                // Stalled fill buffer: drop new bytes, hand over once the output drains.
                w_overrun_nxt = byte_strobe;
                if (w_transfer) begin
                    w_out_ld_fill = 1'b1;
                    w_cnt_clr     = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end
            end else if (byte_strobe) begin
                w_fill_wr = 1'b1;
                if (w_last && ((r_state == ST_FILL) || w_transfer)) begin
                    w_out_ld_new = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_nxt  = ST_HOLD;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
`else
            case (r_state)
                ST_FILL: begin
                    if (byte_strobe && !w_full) begin
                        w_fill_wr = 1'b1;
                        if (w_last) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    w_overrun_nxt = byte_strobe;
                    if (block_ready) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                default: w_state_nxt = ST_FILL;
            endcase
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= ST_FILL;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fill <= '0;
        end else if (w_fill_wr) begin
            r_fill <= w_fill_wr_dat;
        end
    end

`ifdef RX_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out <= '0;
        end else if (w_out_ld_new) begin
            r_out <= w_fill_wr_dat;
        end else if (w_out_ld_fill) begin
            r_out <= r_fill;
        end
    end

    assign block_out = r_out;
`else
    assign block_out = r_fill;
`endif

    assign block_valid = (r_state == ST_HOLD);
    assign overrun     = r_overrun;
    assign fill_count  = w_count;
endmodule
